spi_regbank_burst: RTL

SPI_REGBANK_BURST -- requirements
Module: spi_regbank_burst

---
 rtl/spi_regbank_burst.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/spi_regbank_burst.sv
// SPI slave register bank: command byte then auto-incrementing burst of REG_WIDTH-bit frames
// into R/W config registers or out of read-only status registers; all four SPI modes.
module spi_regbank_burst #(
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter int REG_WIDTH  = 8,
    parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ena,
    input  logic [1:0]                       mode,
    input  logic                             spi_cs_n,
    input  logic                             spi_clk,
    input  logic                             spi_mosi,
    output logic                             spi_miso,
    output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs,
    output logic                             wr_pulse,
    output logic [6:0]                       wr_addr,
    output logic                             addr_err
);

    localparam int         TOTAL     = NUM_CFG + NUM_STATUS;
    localparam logic [6:0] LAST_ADDR = 7'(TOTAL - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                       state_q, state_d;
    logic                         sclk_q;
    logic                         cs_n_q;
    logic [1:0]                   mode_q, mode_d;
    logic [5:0]                   cnt_q, cnt_d;
    logic [REG_WIDTH-1:0]         sr_q, sr_d;
    logic [REG_WIDTH-1:0]         shadow_q, shadow_d;
    logic                         skip_q, skip_d;
    logic                         is_wr_q, is_wr_d;
    logic [6:0]                   addr_q, addr_d;
    logic [NUM_CFG*REG_WIDTH-1:0] cfg_q, cfg_d;
    logic                         wr_pulse_q, wr_pulse_d;
    logic [6:0]                   wr_addr_q, wr_addr_d;
    logic                         err_q, err_d;

    logic                 rise, fall, lead, trail, sample_edge, shift_edge;
    logic [REG_WIDTH-1:0] rx;
    logic [6:0]           addr_nxt;

    function automatic logic is_mapped(input logic [6:0] a);
        return {1'b0, a} < 8'(TOTAL);
    endfunction

    function automatic logic [REG_WIDTH-1:0] reg_at(
        input logic [6:0]                      a,
        input logic [NUM_CFG*REG_WIDTH-1:0]    cfg,
        input logic [NUM_STATUS*REG_WIDTH-1:0] sts
    );
        logic [REG_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CFG; i++)
            if (a == 7'(i)) v = cfg[i*REG_WIDTH +: REG_WIDTH];
        for (int i = 0; i < NUM_STATUS; i++)
            if (a == 7'(NUM_CFG + i)) v = sts[i*REG_WIDTH +: REG_WIDTH];
        return v;
    endfunction

    // Leading edge leaves the idle level set by cpol; cpha picks which edge samples.
    assign rise        = spi_clk & ~sclk_q;
    assign fall        = ~spi_clk & sclk_q;
    assign lead        = mode_q[1] ? fall : rise;
    assign trail       = mode_q[1] ? rise : fall;
    assign sample_edge = mode_q[0] ? trail : lead;
    assign shift_edge  = mode_q[0] ? lead : trail;

    assign rx       = {sr_q[REG_WIDTH-2:0], spi_mosi};
    assign addr_nxt = (addr_q == LAST_ADDR) ? 7'd0 : addr_q + 7'd1;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        shadow_d   = shadow_q;
        skip_d     = skip_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        cfg_d      = cfg_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Only a genuine falling edge of chip select starts a transaction.
                if (!spi_cs_n && cs_n_q) begin
                    state_d = CMD;
                    mode_d  = mode;
                    err_d   = 1'b0;
                    sr_d    = '0;
                end
            end
            CMD: begin
                if (spi_cs_n) begin
                    state_d = IDLE;
                end else if (sample_edge) begin
                    sr_d = rx;
                    if (cnt_q == 6'd7) begin
                        cnt_d   = '0;
                        state_d = DATA;
                        is_wr_d = rx[7];
                        addr_d  = rx[6:0];
                        if (!rx[7]) begin
                            shadow_d = reg_at(rx[6:0], cfg_q, status_regs);
                            skip_d   = 1'b1;
                            if (!is_mapped(rx[6:0])) err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            DATA: begin
                if (spi_cs_n) begin
                    state_d = IDLE;
                end else if (sample_edge) begin
                    sr_d = rx;
                    if (cnt_q == 6'(REG_WIDTH - 1)) begin
                        cnt_d  = '0;
                        addr_d = addr_nxt;
                        if (is_wr_q) begin
                            if (addr_q < 7'(NUM_CFG)) begin
                                for (int i = 0; i < NUM_CFG; i++)
                                    if (addr_q == 7'(i)) cfg_d[i*REG_WIDTH +: REG_WIDTH] = rx;
                                wr_pulse_d = 1'b1;
                                wr_addr_d  = addr_q;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            shadow_d = reg_at(addr_nxt, cfg_q, status_regs);
                            skip_d   = 1'b1;
                            if (!is_mapped(addr_nxt)) err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else if (shift_edge) begin
                    // The first shift edge after a load must leave the fresh MSB on the line.
                    if (skip_q) skip_d = 1'b0;
                    else        shadow_d = {shadow_q[REG_WIDTH-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        sclk_q <= spi_clk;
        if (rst) begin
            state_q    <= IDLE;
            cs_n_q     <= 1'b0;
            mode_q     <= 2'b00;
            cnt_q      <= '0;
            sr_q       <= '0;
            shadow_q   <= '0;
            skip_q     <= 1'b0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            cfg_q      <= CFG_RESET;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_n_q     <= spi_cs_n;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            shadow_q   <= shadow_d;
            skip_q     <= skip_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            cfg_q      <= cfg_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            err_q      <= err_d;
        end
    end

    assign spi_miso    = (state_q == DATA) && !is_wr_q && shadow_q[REG_WIDTH-1];
    assign config_regs = cfg_q;
    assign wr_pulse    = wr_pulse_q;
    assign wr_addr     = wr_addr_q;
    assign addr_err    = err_q;

    logic unused_ok;
    assign unused_ok = ^{ena, sr_q[REG_WIDTH-1]};

endmodule
